// File: rtl/rib_ram_slave.sv
// rib_ram_slave: RIB data-side RAM responder with fixed wait states and a one-cycle ack.
// Define RIB_RAM_RANGE_CHK_EN to flag (err_o) and suppress accesses outside BASE_ADDR's region.
module rib_ram_slave #(
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        busy_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
`ifdef RIB_RAM_RANGE_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              cap_we, cap_ok;
    logic [ADDR_W-1:0] cap_word;
    logic [31:0]       cap_data;
    logic [31:0]       mem [2**ADDR_W];
    logic              in_range, go, commit, c_we, c_ok;
    logic [ADDR_W-1:0] c_word;
    logic [31:0]       c_data;
    logic              unused_ok;

    assign unused_ok = ^addr_i[1:0];

    // With zero wait states the access commits on the capture edge, straight from the inputs
    always_comb begin
        in_range = !CHK || (addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
        go       = (state == IDLE) && req_i;
        commit   = (go && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
        c_we     = go ? we_i : cap_we;
        c_ok     = go ? in_range : cap_ok;
        c_word   = go ? addr_i[ADDR_W+1:2] : cap_word;
        c_data   = go ? data_i : cap_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_we   <= 1'b0;
            cap_ok   <= 1'b0;
            cap_word <= '0;
            cap_data <= '0;
            data_o   <= '0;
            ack_o    <= 1'b0;
            busy_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            ack_o  <= commit;
            err_o  <= commit && !c_ok;
            busy_o <= commit || go || state == WAIT;
            state  <= commit ? ACK : go ? WAIT : state == ACK ? IDLE : state;
            if (commit && !c_we)
                data_o <= c_ok ? mem[c_word] : '0;
            if (go) begin
                cap_we   <= we_i;
                cap_ok   <= in_range;
                cap_word <= addr_i[ADDR_W+1:2];
                cap_data <= data_i;
                cnt      <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Array has no reset; the write is gated by commit so a reset mid-access drops it
    always_ff @(posedge clk) begin
        if (commit && c_we && c_ok)
            mem[c_word] <= c_data;
    end
endmodule

// File: tb/tb_rib_ram_slave.sv
// tb_rib_ram_slave: randomized self-checking bench for rib_ram_slave at WAIT_CYCLES 1, 0 and 15.
// Expected values come from a word-array model of the RAM plus the documented latency rules.
module tb_rib_ram_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req [3];
    logic        we  [3];
    logic        ack [3];
    logic        busy[3];
    logic        err [3];
    logic [31:0] addr[3];
    logic [31:0] wdat[3];
    logic [31:0] rdat[3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mdl [3][4096];
    logic [31:0] last[3];

`ifdef RIB_RAM_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rib_ram_slave #(.WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : 15)) u_dut (
            .clk(clk), .rst(rst), .req_i(req[g]), .we_i(we[g]), .addr_i(addr[g]),
            .data_i(wdat[g]), .data_o(rdat[g]), .ack_o(ack[g]), .busy_o(busy[g]), .err_o(err[g])
        );
    end

    function automatic int waits(input int d);
        return d == 0 ? 1 : d == 1 ? 0 : 15;
    endfunction

    // Region of BASE_ADDR 32'h1000_0000 with ADDR_W=12: bits [31:14] must equal 18'h04000
    function automatic bit in_rng(input logic [31:0] a);
        return !CHK || a[31:14] == 18'h04000;
    endfunction

    task automatic do_access(input int d, input logic w, input logic [31:0] a, input logic [31:0] v);
        int n;
        bit got, busy_bad, ok;
        logic [31:0] exp_d;
        ok = in_rng(a);
        exp_d = w ? last[d] : (ok ? mdl[d][a[13:2]] : 32'h0);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdat[d] = v;
        n = 0; got = 0; busy_bad = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (busy[d] !== 1'b1) busy_bad = 1;
            if (ack[d] === 1'b1) begin
                got = 1;
                req[d] = 1'b0;
            end else begin
                we[d] = 1'($urandom); addr[d] = $urandom; wdat[d] = $urandom;
            end
        end
        checks++;
        if (!got || n != waits(d) + 1) begin
            errors++;
            $display("FAIL latency dut%0d addr=%h: ack after %0d cycles (seen=%0d), expected %0d", d, a, n, got, waits(d) + 1);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL busy_span dut%0d addr=%h: busy_o low during access, expected high", d, a);
        end
        checks++;
        if (rdat[d] !== exp_d) begin
            errors++;
            $display("FAIL data dut%0d we=%0d addr=%h: data_o=%h expected %h", d, w, a, rdat[d], exp_d);
        end
        checks++;
        if (err[d] !== !ok) begin
            errors++;
            $display("FAIL err dut%0d addr=%h: err_o=%b expected %b", d, a, err[d], !ok);
        end
        if (w && ok) mdl[d][a[13:2]] = v;
        if (!w) last[d] = exp_d;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ack[d] !== 1'b0 || busy[d] !== 1'b0) begin
            errors++;
            $display("FAIL tail dut%0d: ack_o=%b busy_o=%b after ACK, expected 0 0", d, ack[d], busy[d]);
        end
    endtask

    task automatic test_reset();
        int n;
        @(negedge clk);
        rst = 1'b0;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1000_0040; wdat[0] = 32'hCAFE_0001;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ack[d] !== 1'b0 || busy[d] !== 1'b0 || err[d] !== 1'b0 || rdat[d] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset dut%0d: ack=%b busy=%b err=%b data=%h, expected all 0", d, ack[d], busy[d], err[d], rdat[d]);
                end
            end
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL first_capture: busy_o=%b one edge after reset release, expected 1", busy[0]);
        end
        n = 1;
        while (ack[0] !== 1'b1 && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        req[0] = 1'b0;
        checks++;
        if (n != 2 || rdat[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_write: ack after %0d cycles data_o=%h, expected 2 and 00000000", n, rdat[0]);
        end
        mdl[0][16] = 32'hCAFE_0001;
        @(posedge clk);
    endtask

    task automatic test_write_read();
        do_access(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF);
        do_access(0, 1'b0, 32'h1000_0010, 32'h0);
    endtask

    task automatic test_back_to_back();
        int t[3];
        logic [31:0] dv[3];
        int k, n;
        for (int i = 0; i < 3; i++) do_access(0, 1'b1, 32'h1000_0000 + 32'(i * 4), $urandom);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h1000_0000;
        k = 0; n = 0;
        while (n < 30) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (ack[0] === 1'b1) begin
                if (k < 3) begin
                    t[k] = cyc;
                    dv[k] = rdat[0];
                end
                k++;
                if (k < 3) addr[0] = 32'h1000_0000 + 32'(k * 4);
                else req[0] = 1'b0;
            end
        end
        checks++;
        if (k != 3) begin
            errors++;
            $display("FAIL b2b_count: %0d acks, expected 3", k);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (k < 3 || dv[i] !== mdl[0][i]) begin
                errors++;
                $display("FAIL b2b_data%0d: data_o=%h expected %h", i, dv[i], mdl[0][i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (k < 3 || t[i] - t[i-1] != 3) begin
                errors++;
                $display("FAIL b2b_spacing%0d: %0d cycles, expected 3", i, t[i] - t[i-1]);
            end
        end
        last[0] = mdl[0][2];
    endtask

    task automatic test_latency();
        logic [31:0] a[4];
        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = 32'h1000_0000 | 32'($urandom_range(0, 4095) << 2);
                do_access(d, 1'b1, a[i], $urandom);
            end
            for (int i = 3; i >= 0; i--) do_access(d, 1'b0, a[i], 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_access(0, 1'b1, 32'h1000_0014, 32'h0BAD_F00D);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1000_0014; wdat[0] = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: busy_o=%b after capture, expected 1", busy[0]);
        end
        rst = 1'b0;
        req[0] = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack[0] !== 1'b0) seen = 1;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack[0] !== 1'b0) seen = 1;
        end
        checks++;
        if (seen || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ack seen=%0d busy_o=%b, expected 0 0", seen, busy[0]);
        end
        for (int d = 0; d < 3; d++) last[d] = 32'h0;
        do_access(0, 1'b0, 32'h1000_0014, 32'h0);
    endtask

    task automatic test_range();
        do_access(0, 1'b1, 32'h2000_0010, 32'hA5A5_A5A5);
        do_access(0, 1'b0, 32'h1000_0010, 32'h0);
        do_access(0, 1'b0, 32'h2000_0010, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 8; i++) do_access(0, 1'b1, 32'h1000_0000 + 32'(i * 4), $urandom);
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 1) == 1 ? 32'h1000_0000 : 32'h2000_0000) | 32'($urandom_range(0, 7) << 2);
            do_access(0, 1'($urandom), a, $urandom);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; wdat[d] = 32'h0; last[d] = 32'h0;
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_latency();
        test_reset_mid();
        test_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
